// File: rtl/ss_sd_pkg.sv
// Shared types and constants for the SCSI <-> HPS sector bridge.
// Holds the bridge state enum, the latched request payload, sector
// geometry and the drive-slot indices.
package ss_sd_pkg;

    localparam int unsigned SECT_WORDS = 256;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned LBA_W      = 32;
    localparam int unsigned NUM_DRV    = 3;

    localparam logic [1:0] DRV_HD  = 2'd0;
    localparam logic [1:0] DRV_HD2 = 2'd1;
    localparam logic [1:0] DRV_CD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_REQ,
        ST_XFER,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Request fields captured on the command handshake.
    typedef struct packed {
        logic [1:0]       drv;
        logic             wr;
        logic [LBA_W-1:0] lba;
    } sect_req_t;

    // One-hot HPS strobe for a drive slot; slot 3 maps to no strobe.
    function automatic logic [NUM_DRV-1:0] drv_onehot(input logic [1:0] drv);
        logic [NUM_DRV-1:0] oh;
        oh = '0;
        case (drv)
            DRV_HD:  oh = 3'b001;
            DRV_HD2: oh = 3'b010;
            DRV_CD:  oh = 3'b100;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/scsi_sd_bridge_sect_buf.sv
// sect_buf: 256x16 simple dual-port sector buffer.
// Ports:
//   clk, reset        - clock; reset clears only the read data register
//   we_i/waddr_i/wdata_i - write port
//   raddr_i/rdata_o   - registered read port (data one cycle after address)
module sect_buf
    import ss_sd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [SECT_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // Storage array.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; reset so the HPS-facing data starts at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/scsi_sd_bridge.sv
// scsi_sd_bridge: moves one 512-byte sector between the SCSI emulation
// and the HPS virtual-disk port, staging it in sect_buf.
// Ports:
//   clk_sys, reset                 - clock, synchronous active-high reset
//   req_*                          - sector command (drive, direction, LBA)
//   wr_*                           - 256-word write stream into the buffer
//   rd_*                           - 256-word read stream out of the buffer
//   done_valid/done_err            - completion pulse and status
//   img_mounted/img_size           - image mount notifications
//   sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_* - hps_io virtual-disk handshake
module scsi_sd_bridge
    import ss_sd_pkg::*;
#(
    parameter int unsigned TIMEOUT = 50000000
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_drv,
    input  logic                req_wr,
    input  logic [LBA_W-1:0]    req_lba,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [WORD_W-1:0]   wr_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [WORD_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                done_valid,
    output logic                done_err,
    input  logic [NUM_DRV-1:0]  img_mounted,
    input  logic [63:0]         img_size,
    output logic [LBA_W-1:0]    sd_lba,
    output logic [NUM_DRV-1:0]  sd_rd,
    output logic [NUM_DRV-1:0]  sd_wr,
    input  logic                sd_ack,
    input  logic [ADDR_W-1:0]   sd_buff_addr,
    input  logic [WORD_W-1:0]   sd_buff_dout,
    input  logic                sd_buff_wr,
    output logic [WORD_W-1:0]   sd_buff_din
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SECT_WORDS - 1);
    localparam logic [31:0]       TMO_LIM  = 32'(TIMEOUT);

    state_e             state_q, state_d;
    sect_req_t          req_q, req_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic               ram_v_q, ram_v_d;
    logic [31:0]        tmo_q, tmo_d, tmo_inc;
    logic               err_d;

    logic               req_ready_q, wr_ready_q;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_last_q, rd_last_d;
    logic [WORD_W-1:0]  rd_data_q, rd_data_d;
    logic               done_valid_q, done_err_q;
    logic [LBA_W-1:0]   sd_lba_q, sd_lba_d;
    logic [NUM_DRV-1:0] sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;

    logic               buf_we;
    logic [ADDR_W-1:0]  buf_waddr, buf_raddr;
    logic [WORD_W-1:0]  buf_wdata, buf_rdata;

    // Image sizes in sectors; intentionally survives reset (0 = unmounted).
    logic [LBA_W-1:0]   size_q [NUM_DRV];
    logic [LBA_W-1:0]   drv_size;
    logic               drv_legal;

    logic               unused_img_bits;
    assign unused_img_bits = ^{img_size[63:41], img_size[8:0]};

    // Size table update; a request in the same cycle still sees the old entry.
    always_ff @(posedge clk_sys) begin
        for (int unsigned d = 0; d < NUM_DRV; d++) begin
            if (img_mounted[d]) begin
                size_q[d] <= img_size[40:9];
            end
        end
    end

    // Size lookup for the incoming request.
    always_comb begin
        drv_size  = '0;
        drv_legal = 1'b1;
        case (req_drv)
            DRV_HD:  drv_size = size_q[0];
            DRV_HD2: drv_size = size_q[1];
            DRV_CD:  drv_size = size_q[2];
            default: drv_legal = 1'b0;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        ram_v_d    = ram_v_q;
        tmo_d      = tmo_q;
        err_d      = 1'b0;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_data_d  = rd_data_q;
        buf_we     = 1'b0;
        buf_waddr  = cnt_q;
        buf_wdata  = wr_data;
        tmo_inc    = (tmo_q == '1) ? tmo_q : tmo_q + 32'd1;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d = '{drv: req_drv, wr: req_wr, lba: req_lba};
                    cnt_d = '0;
                    if (!drv_legal || (req_lba >= drv_size)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else if (req_wr) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_REQ;
                        tmo_d   = '0;
                    end
                end
            end
            ST_FILL: begin
                if (wr_valid && wr_ready_q) begin
                    buf_we = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_REQ;
                        tmo_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_REQ: begin
                if (sd_ack) begin
                    state_d = ST_XFER;
                end else if (tmo_inc >= TMO_LIM) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            ST_XFER: begin
                if (!req_q.wr && sd_buff_wr) begin
                    buf_we    = 1'b1;
                    buf_waddr = sd_buff_addr;
                    buf_wdata = sd_buff_dout;
                end
                if (!sd_ack) begin
                    if (req_q.wr) begin
                        state_d = ST_DONE;
                    end else begin
                        // Prefetch word 0 on the transition cycle.
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                        ram_v_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (rd_valid_q && rd_ready) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    if (rd_last_q) begin
                        state_d = ST_DONE;
                    end
                end
                // RAM output always holds buffer[cnt_q]; move it to the port
                // whenever the output register is empty or being consumed.
                if (ram_v_q && (!rd_valid_q || rd_ready)) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = buf_rdata;
                    rd_last_d  = (cnt_q == LAST_IDX);
                    if (cnt_q == LAST_IDX) begin
                        ram_v_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Drain reads the next index so the RAM output tracks cnt_q.
        buf_raddr = (state_d == ST_DRAIN) ? cnt_d : sd_buff_addr;

        sd_rd_d  = '0;
        sd_wr_d  = '0;
        sd_lba_d = sd_lba_q;
        if (state_d == ST_REQ) begin
            sd_lba_d = req_d.lba;
            if (req_d.wr) begin
                sd_wr_d = drv_onehot(req_d.drv);
            end else begin
                sd_rd_d = drv_onehot(req_d.drv);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            cnt_q        <= '0;
            ram_v_q      <= 1'b0;
            tmo_q        <= '0;
            req_ready_q  <= 1'b1;
            wr_ready_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_data_q    <= '0;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
            sd_lba_q     <= '0;
            sd_rd_q      <= '0;
            sd_wr_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            ram_v_q      <= ram_v_d;
            tmo_q        <= tmo_d;
            req_ready_q  <= (state_d == ST_IDLE);
            wr_ready_q   <= (state_d == ST_FILL);
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            rd_data_q    <= rd_data_d;
            done_valid_q <= (state_d == ST_DONE);
            done_err_q   <= err_d;
            sd_lba_q     <= sd_lba_d;
            sd_rd_q      <= sd_rd_d;
            sd_wr_q      <= sd_wr_d;
        end
    end

    sect_buf u_buf (
        .clk     (clk_sys),
        .reset   (reset),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (buf_wdata),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    assign req_ready   = req_ready_q;
    assign wr_ready    = wr_ready_q;
    assign rd_valid    = rd_valid_q;
    assign rd_last     = rd_last_q;
    assign rd_data     = rd_data_q;
    assign done_valid  = done_valid_q;
    assign done_err    = done_err_q;
    assign sd_lba      = sd_lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_buff_din = buf_rdata;

endmodule

// File: tb/tb_scsi_sd_bridge.sv
// Self-checking bench for scsi_sd_bridge: directed cases plus randomized
// sector traffic against a sector-level disk/size-table model.
module tb_scsi_sd_bridge;

    localparam int unsigned TMO = 100;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wr;
    logic [1:0]  req_drv;
    logic [31:0] req_lba;
    logic        wr_valid, wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [15:0] rd_data;
    logic        done_valid, done_err;
    logic [2:0]  img_mounted;
    logic [63:0] img_size;
    logic [31:0] sd_lba;
    logic [2:0]  sd_rd, sd_wr;
    logic        sd_ack, sd_buff_wr;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout, sd_buff_din;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mounted sizes in sectors and disk contents per (drive, lba, word).
    logic [31:0] size_m [3];
    logic [15:0] disk [longint];

    always #5 clk_sys = ~clk_sys;

    scsi_sd_bridge #(.TIMEOUT(TMO)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_drv      (req_drv),
        .req_wr       (req_wr),
        .req_lba      (req_lba),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .done_valid   (done_valid),
        .done_err     (done_err),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp_v, $time);
        end
    endtask

    function automatic longint dkey(input logic [1:0] d, input logic [31:0] l, input int i);
        return longint'({22'd0, d, l, 8'(i)});
    endfunction

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 1);
        check_eq({tag, "_wr_ready"}, wr_ready, 0);
        check_eq({tag, "_rd"}, {rd_valid, rd_last, rd_data}, 0);
        check_eq({tag, "_done"}, {done_valid, done_err}, 0);
        check_eq({tag, "_sd_lba"}, sd_lba, 0);
        check_eq({tag, "_sd_rdwr"}, {sd_rd, sd_wr}, 0);
        check_eq({tag, "_sd_din"}, sd_buff_din, 0);
    endtask

    task automatic mount(input logic [1:0] d, input logic [63:0] bytes);
        @(negedge clk_sys);
        img_mounted = 3'b001 << d;
        img_size    = bytes;
        @(negedge clk_sys);
        img_mounted = 3'b000;
        size_m[d]   = bytes[40:9];
    endtask

    // mode: 0 normal, 1 no sd_ack, 2 reset mid-XFER (read), 3 mount in the
    // request cycle, 4 mount mid-XFER (read). wpat 1 = i^A5A5 write data.
    task automatic xact(input logic [1:0] drv, input logic wr, input logic [31:0] lba,
                        input int mode, input int wpat, input int stall_at,
                        input logic [63:0] mnt_bytes);
        logic [15:0] wdat [256];
        logic [15:0] exp_w [256];
        logic [2:0]  oh;
        bit          exp_err, hs, stalled;
        int          i, j, n, guard, hold;

        oh      = (drv == 2'd3) ? 3'b000 : (3'b001 << drv);
        exp_err = (drv == 2'd3) ? 1'b1 : (lba >= size_m[drv]);
        for (int k = 0; k < 256; k++) begin
            wdat[k] = (wpat == 1) ? (16'(k) ^ 16'hA5A5) : 16'($urandom);
        end

        @(negedge clk_sys);
        req_drv = drv; req_wr = wr; req_lba = lba; req_valid = 1'b1;
        if (mode == 3) begin
            img_mounted = oh;
            img_size    = mnt_bytes;
        end
        check_eq("req_ready", req_ready, 1);
        @(posedge clk_sys); #1;
        req_valid   = 1'b0;
        img_mounted = 3'b000;
        if (mode == 3 && drv != 2'd3) size_m[drv] = mnt_bytes[40:9];

        if (exp_err) begin
            check_eq("err_done_valid", done_valid, 1);
            check_eq("err_done_err", done_err, 1);
            check_eq("err_no_hps", {sd_rd, sd_wr, wr_ready}, 0);
            @(posedge clk_sys); #1;
            check_eq("err_done_pulse", done_valid, 0);
            return;
        end

        if (wr) begin
            check_eq("fill_ready", wr_ready, 1);
            i = 0; guard = 0;
            while (i < 256 && guard < 2000) begin
                if ($urandom_range(3) == 0) begin
                    wr_valid = 1'b0;
                end else begin
                    wr_valid = 1'b1;
                    wr_data  = wdat[i];
                end
                hs = wr_valid && wr_ready;
                @(posedge clk_sys); #1;
                guard++;
                if (hs) i++;
            end
            wr_valid = 1'b0;
            check_eq("fill_words", i, 256);
            check_eq("sd_wr_assert", {sd_wr, sd_rd, wr_ready}, {oh, 3'b000, 1'b0});
        end else begin
            check_eq("sd_rd_assert", {sd_rd, sd_wr}, {oh, 3'b000});
        end
        check_eq("sd_lba", sd_lba, lba);

        if (mode == 1) begin
            n = 0; hold = 0;
            while (!done_valid && n < 3 * int'(TMO)) begin
                if ((sd_rd | sd_wr) == oh) hold++;
                @(posedge clk_sys); #1;
                n++;
            end
            check_eq("tmo_cycles", n, TMO);
            check_eq("tmo_strobe_held", hold, TMO);
            check_eq("tmo_err", done_err, 1);
            check_eq("tmo_strobe_drop", {sd_rd, sd_wr}, 0);
            @(posedge clk_sys); #1;
            check_eq("tmo_done_pulse", done_valid, 0);
            return;
        end

        repeat ($urandom_range(5)) begin
            @(posedge clk_sys); #1;
        end
        sd_ack = 1'b1;
        @(posedge clk_sys); #1;
        check_eq("hps_strobe_drop", {sd_rd, sd_wr}, 0);

        if (wr) begin
            for (i = 0; i < 256; i++) begin
                sd_buff_addr = 8'(i);
                @(posedge clk_sys); #1;
                disk[dkey(drv, lba, i)] = sd_buff_din;
                check_eq("hps_wr_data", sd_buff_din, wdat[i]);
            end
        end else begin
            for (i = 0; i < 256; i++) begin
                if (!disk.exists(dkey(drv, lba, i))) disk[dkey(drv, lba, i)] = 16'($urandom);
                exp_w[i]     = disk[dkey(drv, lba, i)];
                sd_buff_wr   = 1'b1;
                sd_buff_addr = 8'(i);
                sd_buff_dout = exp_w[i];
                if (i == 100 && mode == 4) begin
                    img_mounted = oh;
                    img_size    = mnt_bytes;
                end
                if (i == 100 && mode == 2) reset = 1'b1;
                @(posedge clk_sys); #1;
                img_mounted = 3'b000;
                if (i == 100 && mode == 2) begin
                    reset      = 1'b0;
                    sd_buff_wr = 1'b0;
                    check_reset_vals("rst_xfer");
                    repeat (3) begin
                        @(posedge clk_sys); #1;
                        check_eq("late_ack_ignored", {req_ready, sd_rd, sd_wr, done_valid}, 8'b1000_0000);
                    end
                    sd_ack = 1'b0;
                    return;
                end
            end
            sd_buff_wr = 1'b0;
            if (mode == 4) size_m[drv] = mnt_bytes[40:9];
        end

        sd_ack = 1'b0;
        @(posedge clk_sys); #1;
        if (wr) begin
            check_eq("wr_done", {done_valid, done_err}, 2'b10);
            @(posedge clk_sys); #1;
            check_eq("wr_done_pulse", done_valid, 0);
            return;
        end

        check_eq("drain_lat1", rd_valid, 0);
        @(posedge clk_sys); #1;
        check_eq("drain_lat2", rd_valid, 1);
        j = 0; guard = 0; stalled = 1'b0;
        while (j < 256 && guard < 2000) begin
            if (j == stall_at && !stalled) begin
                stalled  = 1'b1;
                rd_ready = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    check_eq("stall_hold", {rd_valid, rd_data}, {1'b1, exp_w[j]});
                    @(posedge clk_sys); #1;
                end
            end
            rd_ready = ($urandom_range(3) != 0);
            hs = rd_valid && rd_ready;
            if (hs) begin
                check_eq("rd_data", rd_data, exp_w[j]);
                check_eq("rd_last", rd_last, (j == 255));
            end
            @(posedge clk_sys); #1;
            guard++;
            if (hs) j++;
        end
        rd_ready = 1'b0;
        check_eq("drain_words", j, 256);
        check_eq("rd_done", {done_valid, done_err, rd_valid}, 3'b100);
        @(posedge clk_sys); #1;
        check_eq("rd_done_pulse", done_valid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rdrv;
        logic [31:0] rlba;

        reset = 1'b1;
        req_valid = 1'b0; req_drv = 2'd0; req_wr = 1'b0; req_lba = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        img_mounted = 3'b000; img_size = '0;
        sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
        for (int d = 0; d < 3; d++) size_m[d] = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        reset = 1'b0;
        check_reset_vals("por");

        // Unmounted drive rejects without HPS traffic.
        xact(2'd2, 1'b0, 32'd0, 0, 0, -1, 64'd0);

        mount(2'd0, 64'h100000);
        mount(2'd1, 64'h4000);
        for (int k = 0; k < 256; k++) disk[dkey(2'd0, 32'd5, k)] = 16'(16'h1234 + k);

        xact(2'd0, 1'b0, 32'd5,     0, 0, -1, 64'd0);   // read 0x1234+i
        xact(2'd1, 1'b1, 32'd7,     0, 1, -1, 64'd0);   // write i^A5A5
        xact(2'd1, 1'b0, 32'd7,     0, 0, -1, 64'd0);   // read it back
        xact(2'd0, 1'b0, 32'h800,   0, 0, -1, 64'd0);   // first LBA past end
        xact(2'd0, 1'b0, 32'h7FF,   0, 0, -1, 64'd0);   // last valid LBA
        xact(2'd3, 1'b0, 32'd0,     0, 0, -1, 64'd0);   // illegal slot
        xact(2'd0, 1'b0, 32'd3,     1, 0, -1, 64'd0);   // timeout
        xact(2'd0, 1'b0, 32'd9,     0, 0, 37, 64'd0);   // stall at word 37
        xact(2'd1, 1'b0, 32'd40,    3, 0, -1, 64'h10000); // old size wins
        xact(2'd1, 1'b0, 32'd40,    0, 0, -1, 64'd0);   // new size active
        xact(2'd0, 1'b0, 32'd11,    2, 0, -1, 64'd0);   // reset mid-XFER
        mount(2'd2, 64'h200000);
        xact(2'd2, 1'b0, 32'd0,     0, 0, -1, 64'd0);
        xact(2'd0, 1'b0, 32'h800,   0, 0, -1, 64'd0);   // table kept over reset
        xact(2'd0, 1'b1, 32'd12,    0, 0, -1, 64'd0);
        xact(2'd0, 1'b0, 32'd12,    0, 0, -1, 64'd0);
        xact(2'd0, 1'b0, 32'd13,    4, 0, -1, 64'h1000); // shrink mid-transfer
        xact(2'd0, 1'b0, 32'd13,    0, 0, -1, 64'd0);   // now out of range

        for (int d = 0; d < 3; d++) mount(2'(d), 64'($urandom_range(4, 20)) * 64'd512);
        for (int r = 0; r < 20; r++) begin
            rdrv = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
            rlba = 32'($urandom_range(24));
            xact(rdrv, 1'($urandom_range(1)), rlba, 0, 0, $urandom_range(300), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
